// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM key front end: channel FSM states, default timing,
// and the bit position of each board key inside the key vector.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        PRESSED,
        REPEAT,
        DB_RELEASE
    } key_state_t;

    localparam int DEBOUNCE_CNT_DEF = 1000000;
    localparam int HOLD_CNT_DEF     = 25000000;
    localparam int REPEAT_CNT_DEF   = 5000000;

    localparam int KEY_ADD_DUTY   = 3;
    localparam int KEY_SUB_DUTY   = 2;
    localparam int KEY_ADD_PERIOD = 1;
    localparam int KEY_SUB_PERIOD = 0;

    function automatic int cnt_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, debounce/hold/repeat FSM and its shared counter.
// Auto-repeat states are only built when KEY_AUTO_REPEAT_EN is defined.
module key_channel
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int HOLD_CNT     = HOLD_CNT_DEF,
    parameter int REPEAT_CNT   = REPEAT_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse,
    output logic level
);

    localparam int CNT_MAX = cnt_max3(DEBOUNCE_CNT, HOLD_CNT, REPEAT_CNT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

    logic             sync1;
    logic             sync2;
    logic             press;
    key_state_t       state;
    key_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             level_nxt;

    // Synchroniser resets to "released" so a key held through reset is seen as a new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign press = ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            level <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        level_nxt = level;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!press) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!press) begin
                    state_nxt = DB_RELEASE;
                    cnt_nxt   = '0;
                end
`ifdef KEY_AUTO_REPEAT_EN
                else if (cnt == HOLD_LAST) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
`ifdef KEY_AUTO_REPEAT_EN
            REPEAT: begin
                if (!press) begin
                    state_nxt = DB_RELEASE;
                    cnt_nxt   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif
            DB_RELEASE: begin
                // A press seen mid-release is bounce: return to held without a pulse.
                if (press) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/key_scan_module.sv
// Debounced press/auto-repeat pulses for the PWM adjust keys, one independent channel per key.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_scan_module
    import pwm_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int HOLD_CNT     = HOLD_CNT_DEF,
    parameter int REPEAT_CNT   = REPEAT_CNT_DEF
) (
    input  logic                CLK,
    input  logic                Rst,
    input  logic [NUM_KEYS-1:0] Key_In,
    output logic [NUM_KEYS-1:0] Key_Pulse,
    output logic [NUM_KEYS-1:0] Key_Level
);

    logic [NUM_KEYS-1:0] ch_pulse;
    logic [NUM_KEYS-1:0] ch_level;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .HOLD_CNT     (HOLD_CNT),
            .REPEAT_CNT   (REPEAT_CNT)
        ) u_ch (
            .clk   (CLK),
            .rst   (Rst),
            .key_n (Key_In[i]),
            .pulse (ch_pulse[i]),
            .level (ch_level[i])
        );
    end

    // Boundary register so the adjust stage sees all keys from one flop bank.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            Key_Pulse <= '0;
            Key_Level <= '0;
        end else begin
            Key_Pulse <= ch_pulse;
            Key_Level <= ch_level;
        end
    end

endmodule

// File: tb/tb_key_scan_module.sv
// Bench for key_scan_module: run-length reference model plus directed timing checks.
module tb_key_scan_module;
    import pwm_pkg::*;

    localparam int NK   = 4;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          Rst;
    logic [NK-1:0] Key_In;
    logic [NK-1:0] Key_Pulse;
    logic [NK-1:0] Key_Level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    key_scan_module #(
        .NUM_KEYS(NK), .DEBOUNCE_CNT(DB), .HOLD_CNT(HOLD), .REPEAT_CNT(REP)
    ) dut (
        .CLK(CLK), .Rst(Rst), .Key_In(Key_In), .Key_Pulse(Key_Pulse), .Key_Level(Key_Level)
    );

    always #5 CLK = ~CLK;

    // Model: per key, count runs of pressed/released raw samples; outputs appear 3 edges later.
    int            run1 [NK];
    int            run0 [NK];
    int            tmr  [NK];
    bit            lvl  [NK];
    bit            rep  [NK];
    logic [NK-1:0] p0, p1, p2, exp_pulse;
    logic [NK-1:0] l0, l1, l2, exp_level;

    task automatic model_edge();
        logic [NK-1:0] mp;
        logic [NK-1:0] ml;
        bit            s;
        if (Rst) begin
            for (int i = 0; i < NK; i++) begin
                run1[i] = 0; run0[i] = 0; tmr[i] = 0; lvl[i] = 0; rep[i] = 0;
            end
            p0 = '0; p1 = '0; p2 = '0; exp_pulse = '0;
            l0 = '0; l1 = '0; l2 = '0; exp_level = '0;
        end else begin
            mp = '0;
            ml = '0;
            for (int i = 0; i < NK; i++) begin
                s = !Key_In[i];
                if (!lvl[i]) begin
                    run1[i] = s ? run1[i] + 1 : 0;
                    if (run1[i] == DB + 1) begin
                        lvl[i] = 1; mp[i] = 1'b1; tmr[i] = 0; rep[i] = 0; run0[i] = 0; run1[i] = 0;
                    end
                end else if (!s) begin
                    run0[i]++;
                    if (run0[i] == DB + 1) begin
                        lvl[i] = 0; run0[i] = 0; run1[i] = 0;
                    end
                end else if (run0[i] != 0) begin
                    run0[i] = 0; tmr[i] = 0; rep[i] = 0;
                end else begin
                    tmr[i]++;
                    if (AUTO_REP && tmr[i] == (rep[i] ? REP : HOLD)) begin
                        mp[i] = 1'b1; tmr[i] = 0; rep[i] = 1;
                    end
                end
                ml[i] = lvl[i];
            end
            exp_pulse = p2; p2 = p1; p1 = p0; p0 = mp;
            exp_level = l2; l2 = l1; l1 = l0; l0 = ml;
        end
    endtask

    // Drive keys for one cycle; returns at the following falling edge.
    task automatic step(input logic [NK-1:0] k);
        Key_In = k;
        @(posedge CLK);
        cyc++;
        model_edge();
        @(negedge CLK);
    endtask

    function automatic logic [NK-1:0] press_mask(input int idx);
        logic [NK-1:0] m;
        m = '1;
        m[idx] = 1'b0;
        return m;
    endfunction

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step('1);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(c[0] ? '1 : '0);
            n_checks++;
            if ({Key_Pulse, Key_Level} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs: got pulse=%b level=%b, want 0000/0000", Key_Pulse, Key_Level);
            end
        end
        Rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step('1);
            n_checks++;
            if ({Key_Pulse, Key_Level} !== 8'h00) begin
                n_fail++;
                $display("FAIL post_reset_idle: got pulse=%b level=%b, want 0000/0000", Key_Pulse, Key_Level);
            end
        end
    endtask

    task automatic test_clean_press();
        int t0 = 0, np = 0, pe = -1, rise = -1, fall = -1;
        idle(12);
        for (int c = 0; c < 40; c++) begin
            step(c < 15 ? press_mask(KEY_ADD_DUTY) : '1);
            if (c == 0) t0 = cyc;
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL clean_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
            if (Key_Pulse[KEY_ADD_DUTY]) begin np++; pe = cyc - t0; end
            if (Key_Level[KEY_ADD_DUTY] && rise < 0) rise = cyc - t0;
            if (!Key_Level[KEY_ADD_DUTY] && rise >= 0 && fall < 0) fall = cyc - t0;
        end
        n_checks++;
        if (np !== 1 || pe !== DB + 3) begin
            n_fail++;
            $display("FAIL clean_pulse: got count=%0d edge=%0d, want count=1 edge=%0d", np, pe, DB + 3);
        end
        n_checks++;
        if (rise !== DB + 3 || fall !== 15 + DB + 3) begin
            n_fail++;
            $display("FAIL clean_level: got rise=%0d fall=%0d, want %0d/%0d", rise, fall, DB + 3, 15 + DB + 3);
        end
    endtask

    task automatic test_bounce();
        int np = 0, nl = 0;
        logic lowk;
        idle(12);
        for (int c = 0; c < 20; c++) begin
            lowk = (c < 3) || (c >= 5 && c < 8);
            step(lowk ? press_mask(KEY_SUB_DUTY) : '1);
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL bounce_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
            if (Key_Pulse[KEY_SUB_DUTY]) np++;
            if (Key_Level[KEY_SUB_DUTY]) nl++;
        end
        n_checks++;
        if (np !== 0 || nl !== 0) begin
            n_fail++;
            $display("FAIL bounce_reject: got pulses=%0d level_cycles=%0d, want 0/0", np, nl);
        end
    endtask

    task automatic test_auto_repeat();
        int t0 = 0;
        int got[$];
        int want[$];
        if (AUTO_REP) want = '{7, 27, 35, 43, 51, 59};
        else          want = '{7};
        idle(12);
        for (int c = 0; c < 75; c++) begin
            step(c < 60 ? press_mask(KEY_ADD_PERIOD) : '1);
            if (c == 0) t0 = cyc;
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL repeat_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
            if (Key_Pulse[KEY_ADD_PERIOD]) got.push_back(cyc - t0);
        end
        n_checks++;
        if (got.size() !== want.size()) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d pulses, want %0d", got.size(), want.size());
        end
        for (int j = 0; j < want.size(); j++) begin
            n_checks++;
            if (j >= got.size() || got[j] !== want[j]) begin
                n_fail++;
                $display("FAIL repeat_edge[%0d]: got %0d, want %0d", j, (j < got.size()) ? got[j] : -1, want[j]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int t0 = 0, nz = 0, pe = -1;
        logic [NK-1:0] first = '0;
        idle(12);
        for (int c = 0; c < 26; c++) begin
            step(c < 12 ? 4'b0011 : 4'b1111);
            if (c == 0) t0 = cyc;
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL simul_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
            if (Key_Pulse != '0) begin
                nz++;
                if (pe < 0) begin pe = cyc - t0; first = Key_Pulse; end
            end
        end
        n_checks++;
        if (first !== 4'b1100 || nz !== 1 || pe !== DB + 3) begin
            n_fail++;
            $display("FAIL simultaneous: got pulse=%b cycles=%0d edge=%0d, want 1100/1/%0d", first, nz, pe, DB + 3);
        end
    endtask

    task automatic test_reset_mid_hold();
        int t0 = 0, np = 0, pe = -1;
        idle(12);
        for (int c = 0; c < 12; c++) step(press_mask(KEY_SUB_PERIOD));
        n_checks++;
        if (Key_Level[KEY_SUB_PERIOD] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_before_reset: got level=%b, want 1", Key_Level[KEY_SUB_PERIOD]);
        end
        Rst = 1'b1;
        #1;
        n_checks++;
        if ({Key_Pulse, Key_Level} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%b, want 0000/0000", Key_Pulse, Key_Level);
        end
        for (int c = 0; c < 3; c++) begin
            step(press_mask(KEY_SUB_PERIOD));
            n_checks++;
            if ({Key_Pulse, Key_Level} !== 8'h00) begin
                n_fail++;
                $display("FAIL in_reset c=%0d: got %b/%b, want 0000/0000", c, Key_Pulse, Key_Level);
            end
        end
        Rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step(press_mask(KEY_SUB_PERIOD));
            if (c == 0) t0 = cyc;
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL rst_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
            if (Key_Pulse[KEY_SUB_PERIOD]) begin np++; pe = cyc - t0; end
        end
        n_checks++;
        if (np !== 1 || pe !== DB + 3) begin
            n_fail++;
            $display("FAIL reset_repress: got count=%0d edge=%0d, want 1 at %0d", np, pe, DB + 3);
        end
        idle(12);
    endtask

    task automatic test_release_glitch();
        int t0 = 0, drops = 0;
        int got[$];
        int want[$];
        logic lowk;
        if (AUTO_REP) want = '{7, 35};
        else          want = '{7};
        for (int c = 0; c < 55; c++) begin
            lowk = (c < 10) || (c >= 12 && c < 40);
            step(lowk ? press_mask(KEY_ADD_DUTY) : '1);
            if (c == 0) t0 = cyc;
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL glitch_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
            if (Key_Pulse[KEY_ADD_DUTY]) got.push_back(cyc - t0);
            if (cyc - t0 >= 7 && cyc - t0 < 47 && !Key_Level[KEY_ADD_DUTY]) drops++;
        end
        n_checks++;
        if (drops !== 0) begin
            n_fail++;
            $display("FAIL glitch_level: got %0d low cycles while held, want 0", drops);
        end
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL glitch_pulses: got %0d pulses first=%0d, want %0d pulses", got.size(),
                     (got.size() > 0) ? got[0] : -1, want.size());
        end
    endtask

    task automatic test_random();
        logic [NK-1:0] k = '1;
        int hold_left[NK];
        for (int i = 0; i < NK; i++) hold_left[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold_left[i] == 0) begin
                    k[i] = $urandom_range(0, 1);
                    hold_left[i] = (c % 150 < 75) ? $urandom_range(1, 6) : $urandom_range(5, 40);
                end
                hold_left[i]--;
            end
            step(k);
            n_checks++;
            if ({Key_Pulse, Key_Level} !== {exp_pulse, exp_level}) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %b/%b want %b/%b", c, Key_Pulse, Key_Level, exp_pulse, exp_level);
            end
        end
    endtask

    initial begin
        Rst    = 1'b1;
        Key_In = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_release_glitch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
